// File: rtl/ast_pkg.sv
// Shared Avalon-ST definitions: empty-width rule and the packer/window FSM state type.
package ast_pkg;

    typedef enum logic {
        FILL_S  = 1'b0,
        FLUSH_S = 1'b1
    } ast_state_e;

    function automatic int ast_empty_w(input int symbols);
        return (symbols == 1) ? 1 : $clog2(symbols);
    endfunction

endpackage

// File: rtl/ast_pack.sv
// Byte-stream to Avalon-ST source packer: gathers left-justified input bytes into
// full S-symbol beats and marks packet boundaries with sop/eop/empty.
module ast_pack
    import ast_pkg::*;
#(
    parameter int       BYTE_W             = 8,
    parameter int       IN_SYMBOLS         = 8,
    parameter int       AST_SOURCE_SYMBOLS = 8,
    parameter bit       AST_SOURCE_ORDER   = 1'b1,
    parameter int       AST_SOURCE_EMPTY_W = ast_empty_w(AST_SOURCE_SYMBOLS)
) (
    input  logic                                      clk_i,
    input  logic                                      srst_i,
    input  logic [IN_SYMBOLS-1:0][BYTE_W-1:0]         bytes_data_i,
    input  logic [$clog2(IN_SYMBOLS+1)-1:0]           bytes_cnt_i,
    input  logic                                      bytes_last_i,
    input  logic                                      bytes_valid_i,
    output logic                                      bytes_ready_o,
    output logic [AST_SOURCE_SYMBOLS-1:0][BYTE_W-1:0] ast_source_data_o,
    output logic                                      ast_source_valid_o,
    input  logic                                      ast_source_ready_i,
    output logic                                      ast_source_startofpacket_o,
    output logic                                      ast_source_endofpacket_o,
    output logic [AST_SOURCE_EMPTY_W-1:0]             ast_source_empty_o
);

    localparam int S         = AST_SOURCE_SYMBOLS;
    localparam int BUFF_SIZE = S + IN_SYMBOLS;
    localparam int FILL_W    = $clog2(BUFF_SIZE + 1);
    localparam int IDX_W     = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
    localparam int IN_IDX_W  = (IN_SYMBOLS > 1) ? $clog2(IN_SYMBOLS) : 1;

    logic [BYTE_W-1:0] buf_q [BUFF_SIZE];
    logic [BYTE_W-1:0] buf_d [BUFF_SIZE];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    ast_state_e        state_q;
    logic              sop_pending_q;

    logic              in_flush;
    logic              eop_beat;
    logic              pop;
    logic              push;
    logic [FILL_W-1:0] empty_full;
    int                pop_n;
    int                base;
    int                cnt;
    int                src;

    assign in_flush   = (state_q == FLUSH_S);
    assign eop_beat   = in_flush && (fill_q != '0) && (fill_q <= FILL_W'(S));
    assign empty_full = FILL_W'(S) - fill_q;

    // Input ready depends only on registered state (and reset), never on the sink's ready.
    assign bytes_ready_o              = !srst_i && !in_flush && (fill_q <= FILL_W'(S));
    assign ast_source_valid_o         = in_flush ? (fill_q != '0) : (fill_q >= FILL_W'(S));
    assign ast_source_startofpacket_o = ast_source_valid_o && sop_pending_q;
    assign ast_source_endofpacket_o   = eop_beat;
    assign ast_source_empty_o         = eop_beat ? empty_full[AST_SOURCE_EMPTY_W-1:0] : '0;

    assign pop  = ast_source_valid_o && ast_source_ready_i;
    assign push = bytes_valid_i && bytes_ready_o;

    always_comb begin
        for (int k = 0; k < S; k++) begin
            if (AST_SOURCE_ORDER)
                ast_source_data_o[S-1-k] = buf_q[k];
            else
                ast_source_data_o[k] = buf_q[k];
        end
    end

    // Pop first, then append behind whatever remains.
    always_comb begin
        pop_n = 0;
        if (pop)
            pop_n = (int'(fill_q) < S) ? int'(fill_q) : S;
        base = int'(fill_q) - pop_n;
        cnt  = push ? int'(bytes_cnt_i) : 0;
        src  = 0;
        for (int i = 0; i < BUFF_SIZE; i++) begin
            src = i + pop_n;
            if (src < BUFF_SIZE)
                buf_d[i] = buf_q[IDX_W'(src)];
            else
                buf_d[i] = buf_q[i];
            if (i >= base && i < base + cnt)
                buf_d[i] = bytes_data_i[IN_IDX_W'(i - base)];
        end
        fill_d = FILL_W'(base + cnt);
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BUFF_SIZE; i++)
            buf_q[i] <= buf_d[i];
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            fill_q        <= '0;
            state_q       <= FILL_S;
            sop_pending_q <= 1'b1;
        end else begin
            fill_q <= fill_d;
            if (pop)
                sop_pending_q <= eop_beat;
            case (state_q)
                FILL_S:  if (push && bytes_last_i) state_q <= FLUSH_S;
                FLUSH_S: if (fill_q == '0 || (pop && eop_beat)) state_q <= FILL_S;
                default: state_q <= FILL_S;
            endcase
        end
    end

endmodule
